// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the shared 32-bit datapath: sequences fetch/decode/execute,
// handshakes memory via req/ready, counts retired instructions and flags illegal opcodes.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

    localparam logic [SEL_W-1:0] SRC_B_REG  = 2'd0;
    localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'd1;
    localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'd2;
    localparam logic [SEL_W-1:0] ALU_ADD    = 2'd0;
    localparam logic [SEL_W-1:0] ALU_SUB    = 2'd1;
    localparam logic [SEL_W-1:0] ALU_FUNCT  = 2'd2;
    localparam logic [SEL_W-1:0] PC_ALU     = 2'd0;
    localparam logic [SEL_W-1:0] PC_ALUOUT  = 2'd1;
    localparam logic [SEL_W-1:0] PC_JUMP    = 2'd2;

    state_t state;
    state_t state_nx;
    logic   retire;
    logic   flag_illegal;

    // Next state, plus the retire and illegal-opcode events taken on the leaving edge
    always_comb begin
        state_nx     = state;
        retire       = 1'b0;
        flag_illegal = 1'b0;
        case (state)
            FETCH: begin
                if (mem_ready) state_nx = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nx = R_EXEC;
                    OP_LW, OP_SW: state_nx = MEM_ADDR;
                    OP_BEQ:       state_nx = BRANCH;
                    OP_J:         state_nx = JUMP;
                    OP_ADDI:      state_nx = ADDI_EXEC;
                    default: begin
                        flag_illegal = 1'b1;
                        state_nx     = FETCH;
                    end
                endcase
            end
            MEM_ADDR:  state_nx = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ: begin
                if (mem_ready) state_nx = MEM_WB;
            end
            MEM_WRITE: begin
                if (mem_ready) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end
            end
            R_EXEC:    state_nx = R_WB;
            ADDI_EXEC: state_nx = ADDI_WB;
            MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: begin
                retire   = 1'b1;
                state_nx = FETCH;
            end
            default:   state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            retired    <= '0;
            illegal_op <= 1'b0;
        end else begin
            state <= state_nx;
            if (retire)       retired    <= retired + CNT_W'(1);
            if (flag_illegal) illegal_op <= 1'b1;
        end
    end

    // Datapath controls decoded from the current state; forced low while reset is held
    always_comb begin
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = SRC_B_IMM;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                end
                MEM_READ: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_write  = zero;
                end
                JUMP: begin
                    pc_src   = PC_JUMP;
                    pc_write = 1'b1;
                end
                ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                end
                ADDI_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, hand-written reset/wrap sequences and a
// randomized instruction stream checked against a phase-list model of each instruction.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3;
    localparam logic [3:0] S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ADDI_EXEC = 4'd10, S_ADDI_WB = 4'd11;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, mem_read, mem_write, iord, ir_write, pc_write;
    logic             reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_src;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op), .retired(retired),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cycles, rw_cnt, pw_cnt, iw_cnt, mw_cnt;
    int unsigned exp_ret = 0;
    logic        exp_ill = 1'b0;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         fw;
        int         mw;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h08;
    endfunction

    task automatic check_all_zero(input string name);
        check(name, 32'({mem_req, mem_read, mem_write, iord, ir_write, pc_write, reg_write,
                         reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src}), 32'd0);
    endtask

    // One clock: drive ready, sample mid-cycle against the expected state, advance
    task automatic tick(input logic rdy, input logic [3:0] s);
        logic mem_state;
        mem_ready = rdy;
        mem_state = (s == S_MEM_READ) || (s == S_MEM_WRITE);
        @(negedge clk);
        cycles++;
        check("state_dbg", 32'(state_dbg), 32'(s));
        check("mem_req", 32'(mem_req), 32'(mem_state || s == S_FETCH));
        check("iord", 32'(iord), 32'(mem_state));
        case (s)
            S_FETCH:  check("fetch_muxes", 32'({mem_read, alu_src_b}), 32'({1'b1, 2'd1}));
            S_DECODE: check("decode_srcb", 32'(alu_src_b), 32'd2);
            S_BRANCH: check("branch_ctl", 32'({pc_src, alu_op, pc_write}), 32'({2'd1, 2'd1, zero}));
            S_JUMP:   check("jump_ctl", 32'({pc_src, pc_write}), 32'({2'd2, 1'b1}));
            S_R_WB:   check("rwb_ctl", 32'({reg_write, reg_dst, mem_to_reg}), 32'(3'b110));
            S_MEM_WB: check("memwb_ctl", 32'({reg_write, reg_dst, mem_to_reg}), 32'(3'b101));
            default: ;
        endcase
        if (reg_write) rw_cnt++;
        if (pc_write)  pw_cnt++;
        if (ir_write)  iw_cnt++;
        if (mem_write) mw_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Executes one instruction from its phase list; memory phases wait mw cycles, fetch fw
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                             input logic rnd_idle, output int ncyc);
        logic [3:0] ph[$];
        int         waits;
        logic       rdy;
        opcode = op;
        zero   = z;
        cycles = 0; rw_cnt = 0; pw_cnt = 0; iw_cnt = 0; mw_cnt = 0;
        ph.push_back(S_FETCH);
        ph.push_back(S_DECODE);
        case (op)
            6'h00: begin ph.push_back(S_R_EXEC); ph.push_back(S_R_WB); end
            6'h23: begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_READ); ph.push_back(S_MEM_WB); end
            6'h2B: begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_WRITE); end
            6'h04: ph.push_back(S_BRANCH);
            6'h02: ph.push_back(S_JUMP);
            6'h08: begin ph.push_back(S_ADDI_EXEC); ph.push_back(S_ADDI_WB); end
            default: ;
        endcase
        foreach (ph[i]) begin
            if (ph[i] == S_FETCH) waits = fw;
            else if (ph[i] == S_MEM_READ || ph[i] == S_MEM_WRITE) waits = mw;
            else waits = 0;
            for (int w = 0; w < waits; w++) tick(1'b0, ph[i]);
            rdy = 1'b1;
            if (rnd_idle && waits == 0 && ph[i] != S_FETCH && ph[i] != S_MEM_READ && ph[i] != S_MEM_WRITE)
                rdy = 1'($urandom_range(0, 1));
            tick(rdy, ph[i]);
        end
        ncyc = cycles;
        if (is_legal(op)) exp_ret = (exp_ret + 1) % (32'd1 << CNT_W);
        else exp_ill = 1'b1;
        check("ir_write_pulses", 32'(iw_cnt), 32'd1);
        check("pc_write_pulses", 32'(pw_cnt), 32'(1 + ((op == 6'h04 && z) ? 1 : 0) + ((op == 6'h02) ? 1 : 0)));
        check("reg_write_pulses", 32'(rw_cnt), 32'((op == 6'h00 || op == 6'h23 || op == 6'h08) ? 1 : 0));
        check("mem_write_cycles", 32'(mw_cnt), 32'((op == 6'h2B) ? mw + 1 : 0));
        check("retired", 32'(retired), exp_ret);
        check("illegal_op", 32'(illegal_op), 32'(exp_ill));
        check("back_to_fetch", 32'(state_dbg), 32'(S_FETCH));
    endtask

    initial begin
        int         n;
        logic [5:0] op;

        vecs[0]  = '{6'h00, 1'b0, 0, 0, 4};
        vecs[1]  = '{6'h23, 1'b0, 0, 2, 7};
        vecs[2]  = '{6'h2B, 1'b0, 0, 0, 4};
        vecs[3]  = '{6'h04, 1'b1, 0, 0, 3};
        vecs[4]  = '{6'h04, 1'b0, 0, 0, 3};
        vecs[5]  = '{6'h02, 1'b0, 0, 0, 3};
        vecs[6]  = '{6'h08, 1'b0, 0, 0, 4};
        vecs[7]  = '{6'h3F, 1'b0, 0, 0, 2};
        vecs[8]  = '{6'h00, 1'b0, 1, 0, 5};
        vecs[9]  = '{6'h2B, 1'b0, 2, 3, 9};
        vecs[10] = '{6'h23, 1'b1, 0, 0, 5};

        reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        #2;
        check_all_zero("reset_outputs");
        check("reset_state", 32'(state_dbg), 32'd0);
        check("reset_retired", 32'(retired), 32'd0);
        check("reset_illegal", 32'(illegal_op), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick(1'b0, S_FETCH);

        // Mid-cycle reset forces outputs low immediately
        #2 reset = 1'b1;
        #1 check_all_zero("midcycle_reset_outputs");
        check("midcycle_reset_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].z, vecs[i].fw, vecs[i].mw, 1'b0, n);
            check("vec_cycles", 32'(n), 32'(vecs[i].exp_cycles));
        end

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h02;
                5: op = 6'h08;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    if (is_legal(op)) op = 6'h3F;
                end
            endcase
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, n);
        end

        // Counter wrap from all-ones
        for (int i = 0; i < 16 && exp_ret != 15; i++) run_instr(6'h02, 1'b0, 0, 0, 1'b0, n);
        check("retired_all_ones", 32'(retired), 32'd15);
        run_instr(6'h02, 1'b0, 0, 0, 1'b0, n);
        check("retired_wrap", 32'(retired), 32'd0);

        // Reset during a stalled store
        run_instr(6'h3F, 1'b0, 0, 0, 1'b0, n);
        run_instr(6'h00, 1'b0, 0, 0, 1'b0, n);
        opcode = 6'h2B; zero = 1'b0;
        tick(1'b1, S_FETCH);
        tick(1'b1, S_DECODE);
        tick(1'b1, S_MEM_ADDR);
        tick(1'b0, S_MEM_WRITE);
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("sw_abort_outputs");
        check("sw_abort_state", 32'(state_dbg), 32'd0);
        check("sw_abort_retired", 32'(retired), 32'd0);
        check("sw_abort_illegal", 32'(illegal_op), 32'd0);
        @(posedge clk);
        #1 check("sw_abort_mem_write", 32'(mem_write), 32'd0);
        reset = 1'b0;
        exp_ret = 0;
        exp_ill = 1'b0;
        run_instr(6'h00, 1'b0, 0, 0, 1'b0, n);
        check("post_reset_cycles", 32'(n), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
